// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory req/ack handshake, decode-side
// presentation (instr/pc/valid) with stall, and the redirect input.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;

  modport master (
    output imem_req, imem_addr, instr, pc, pc_plus4, valid,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc, pc_plus4, valid,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the fetch PC, keeps at most one memory request
// in flight, and presents one instruction to decode, dropping wrong-path data.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_q;
  logic [31:0] r_req_addr;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic        r_valid;

  logic        w_consume;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_req_plus4;
  logic        w_unused_bits;

  assign w_consume     = r_valid & ~io_bus.stall;
  assign w_redirect_pc = {io_bus.redirect_pc[31:2], 2'b00};
  assign w_req_plus4   = r_req_addr + 32'd4;
  assign w_unused_bits = ^io_bus.redirect_pc[1:0];

  // Fetch FSM, PC and output register; the request stays up in DISCARD so the
  // memory handshake is always completed even after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc_q     <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_imem_req <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
    end else begin
      if (w_consume) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (io_bus.redirect) begin
            r_pc_q  <= w_redirect_pc;
            r_valid <= 1'b0;
          end else if (!r_valid || !io_bus.stall) begin
            r_req_addr <= r_pc_q;
            r_imem_req <= 1'b1;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (io_bus.imem_ack && !io_bus.redirect) begin
            r_instr    <= io_bus.imem_rdata;
            r_pc       <= r_req_addr;
            r_valid    <= 1'b1;
            r_pc_q     <= w_req_plus4;
            r_imem_req <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (io_bus.imem_ack) begin
            r_pc_q     <= w_redirect_pc;
            r_valid    <= 1'b0;
            r_imem_req <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (io_bus.redirect) begin
            r_pc_q  <= w_redirect_pc;
            r_valid <= 1'b0;
            r_state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (io_bus.redirect) begin
            r_pc_q  <= w_redirect_pc;
            r_valid <= 1'b0;
          end
          if (io_bus.imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_valid    <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.imem_req  = r_imem_req;
  assign io_bus.imem_addr = r_req_addr;
  assign io_bus.instr     = r_instr;
  assign io_bus.pc        = r_pc;
  assign io_bus.pc_plus4  = r_pc + 32'd4;
  assign io_bus.valid     = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small memory responder with programmable
// latency feeds a scoreboard of instructions expected at the decode side.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          cnt      = 0;
  int          mem_lat  = 1;
  bit          discard  = 1'b0;
  logic [31:0] exp_next_addr = RESET_PC;
  logic [31:0] held_addr     = 32'd0;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h00500093 + (a - RESET_PC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check presented output, answer memory, update model, advance.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    logic a;
    chk("valid", {31'd0, bus.valid}, {31'd0, (q_pc.size() != 0)});
    if (bus.valid === 1'b1 && q_pc.size() != 0) begin
      chk("instr", bus.instr, q_instr[0]);
      chk("pc", bus.pc, q_pc[0]);
      chk("pc_plus4", bus.pc_plus4, q_pc[0] + 32'd4);
    end
    a = 1'b0;
    if (bus.imem_req === 1'b1) begin
      if (cnt == 0) chk("req_addr", bus.imem_addr, exp_next_addr);
      else          chk("addr_hold", bus.imem_addr, held_addr);
      held_addr = bus.imem_addr;
      a   = (cnt == mem_lat);
      cnt = a ? 0 : cnt + 1;
    end
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.imem_ack    = a;
    bus.imem_rdata  = a ? word(bus.imem_addr) : 32'hDEADBEEF;
    if (bus.valid === 1'b1 && !s && q_pc.size() != 0) begin
      void'(q_pc.pop_front());
      void'(q_instr.pop_front());
    end
    if (r) begin
      q_pc.delete();
      q_instr.delete();
      exp_next_addr = {rpc[31:2], 2'b00};
      if (bus.imem_req === 1'b1 && !a) discard = 1'b1;
    end else if (a && !discard) begin
      q_instr.push_back(word(bus.imem_addr));
      q_pc.push_back(bus.imem_addr);
      exp_next_addr = bus.imem_addr + 32'd4;
    end
    if (a) discard = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    for (int n = 0; n < budget && bus.imem_req !== 1'b1; n++) step(1'b0, 1'b0, 32'd0);
    chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int n = 0; n < budget && bus.valid !== 1'b1; n++) step(1'b0, 1'b0, 32'd0);
    chk("wait_valid", {31'd0, bus.valid}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_addr"},  bus.imem_addr, RESET_PC);
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
    chk({tag, "_instr"}, bus.instr, NOP);
    chk({tag, "_pc"},    bus.pc, RESET_PC);
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] old_addr;
    int          vcount;
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_pc_plus4", bus.pc_plus4, 32'hBFC00004);
    rst = 1'b0;

    // First fetch, memory answers one cycle after request
    mem_lat = 1;
    step(1'b0, 1'b0, 32'd0);
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'hBFC00000);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("first_instr", bus.instr, 32'h00500093);
    chk("first_pc", bus.pc, 32'hBFC00000);
    chk("first_pc4", bus.pc_plus4, 32'hBFC00004);

    // Zero-wait sequential stream: one instruction every two cycles
    mem_lat = 0;
    vcount  = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.valid === 1'b1) vcount++;
      step(1'b0, 1'b0, 32'd0);
    end
    chk("throughput", vcount, 32'd4);
    chk("seq_pc", bus.pc, 32'hBFC00010);

    // Stall holds the output and blocks new requests
    wait_valid(10);
    held_pc = bus.pc;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
      step(1'b1, 1'b0, 32'd0);
    end
    chk("stall_pc", bus.pc, held_pc);
    step(1'b0, 1'b0, 32'd0);
    chk("unstall_req", {31'd0, bus.imem_req}, 32'd1);
    chk("unstall_addr", bus.imem_addr, held_pc + 32'd4);

    // Redirect while a 3-cycle-latency request is outstanding
    mem_lat = 3;
    step(1'b0, 1'b0, 32'd0);
    old_addr = bus.imem_addr;
    step(1'b0, 1'b1, 32'hBFC00100);
    for (int i = 0; i < 10 && bus.imem_req === 1'b1; i++) begin
      chk("discard_addr", bus.imem_addr, old_addr);
      step(1'b0, 1'b0, 32'd0);
    end
    chk("discard_done", {31'd0, bus.imem_req}, 32'd0);
    wait_req(5);
    chk("redir_addr", bus.imem_addr, 32'hBFC00100);

    // Redirect, ack and stall in the same cycle; target low bits ignored
    mem_lat = 1;
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'hBFC00042);
    chk("coinc_valid", {31'd0, bus.valid}, 32'd0);
    wait_req(5);
    chk("coinc_addr", bus.imem_addr, 32'hBFC00040);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("coinc_pc", bus.pc, 32'hBFC00040);
    step(1'b0, 1'b0, 32'd0);

    // Asynchronous reset between edges while a request is pending
    wait_req(5);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    q_pc.delete(); q_instr.delete();
    cnt = 0; discard = 1'b0; exp_next_addr = RESET_PC;
    bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Redirect to the top word, then the sequential fetch wraps to zero
    mem_lat = 0;
    step(1'b0, 1'b1, 32'hFFFFFFFC);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap_req_addr", bus.imem_addr, 32'hFFFFFFFC);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap_pc", bus.pc, 32'hFFFFFFFC);
    chk("wrap_pc4", bus.pc_plus4, 32'h00000000);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap_addr", bus.imem_addr, 32'h00000000);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage feeding the control unit and register file. Holds the program counter, issues word-aligned requests to instruction memory over a req/ack handshake, and presents one fetched instruction with its PC to decode. Consumes the resolved branch/jump redirect (derived from PCsrc/Jump and the computed target) and discards wrong-path fetches.

## Interface

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset
- NOP_INSTR, 32'h00000013, value driven on instr while empty or after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request to instruction memory, registered
- imem_addr  out  32  request address, stable while imem_req high
- imem_ack  in  1  one-cycle pulse, imem_rdata valid in this cycle
- imem_rdata  in  32  returned instruction word
- stall  in  1  decode cannot accept the presented instruction this cycle
- redirect  in  1  one-cycle pulse, control-flow change resolved
- redirect_pc  in  32  target address, valid with redirect
- instr  out  32  presented instruction
- pc  out  32  address of presented instruction
- pc_plus4  out  32  pc + 4, combinational, wraps mod 2^32
- valid  out  1  instr/pc hold a real instruction

## Operation

- State: pc_q (next fetch address), req_addr, output register {instr, pc, valid}, FSM {IDLE, BUSY, DISCARD}.
- Consume: output register is consumed in any cycle with valid=1 and stall=0; valid clears at that edge unless reloaded.
- One outstanding request maximum; a request launches only when the output register is empty or consumed that cycle, so the slot is guaranteed free when ack arrives.
- IDLE: imem_req=0. redirect=1 -> pc_q<=redirect_pc, valid<=0, stay IDLE. Else if valid=0 or stall=0 -> req_addr<=pc_q, go BUSY.
- BUSY: imem_req=1, imem_addr=req_addr.
  - ack=1, redirect=0 -> instr<=imem_rdata, pc<=req_addr, valid<=1, pc_q<=req_addr+4, go IDLE.
  - ack=1, redirect=1 -> data dropped, pc_q<=redirect_pc, valid<=0, go IDLE.
  - ack=0, redirect=1 -> pc_q<=redirect_pc, valid<=0, go DISCARD.
  - ack=0, redirect=0 -> stay.
- DISCARD: imem_req=1 with old req_addr (handshake never abandoned); on ack data dropped, go IDLE. Further redirect overwrites pc_q, stays DISCARD (or goes IDLE if ack same cycle).
- redirect has priority over stall and over ack data.
- redirect_pc[1:0] ignored; pc_q low two bits always 00.
- pc_q + 4 wraps 32'hFFFFFFFC -> 32'h00000000.
- imem_ack outside BUSY/DISCARD is ignored.

## Timing

- Reset values (asynchronous, immediate): FSM=IDLE, pc_q=RESET_PC, req_addr=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, pc=RESET_PC, valid=0.
- First edge after rst falls: launch; imem_req=1 from cycle 1 with imem_addr=RESET_PC.
- Memory ack no earlier than the cycle imem_req is first seen high (registered req, so no combinational loop).
- Latency: ack in cycle N -> valid=1 with that word from cycle N+1.
- Throughput with zero-wait memory (ack same cycle as req) and no stall: one instruction every 2 cycles.
- Redirect in cycle N: valid=0 from N+1; first request to target issues no earlier than N+2 (N+1 in IDLE if not DISCARD).
- rst asserted mid-request: imem_req drops immediately, outstanding request abandoned; memory must tolerate this.

## Test plan

- Reset: hold rst, then release; memory returns 32'h00500093 one cycle after req -> imem_addr=32'hBFC00000, then valid=1, instr=32'h00500093, pc=32'hBFC00000, pc_plus4=32'hBFC00004.
- Sequential: memory returns incrementing words, stall=0 -> pc sequence BFC00000, BFC00004, BFC00008, valid high every other cycle, no duplicates or gaps.
- Stall: assert stall 5 cycles while valid=1 -> instr/pc unchanged, imem_req stays 0; on release next request to pc+4 issues following cycle.
- Redirect during wait: memory latency 3, redirect to 32'hBFC00100 one cycle after req -> imem_addr held at old address until ack, old data never reaches valid=1, next request addr=32'hBFC00100.
- Redirect coincident with ack and stall: redirect=1, ack=1, stall=1 same cycle, redirect_pc=32'hBFC00042 -> valid=0 next cycle, next fetch addr=32'hBFC00040.
- Async reset mid-BUSY and wrap: rst pulse between clock edges -> outputs at reset values before next edge; redirect to 32'hFFFFFFFC -> following fetch addr=32'h00000000.
